sd_dat_tx: RTL
==============

Name: sd_dat_tx

Overview:
SD-host DAT0 write-path transmitter, the consumer on the read side of the asynchronous data FIFO that the ADMA engine fills.
- Pops 32-bit words from the FIFO and serialises each block in 1-bit mode: start bit, data, CRC16, end bit.
- Samples the card's CRC-status token and busy period before sending the next block.
- Reports completion and errors back to the register/ADMA layer.

Parameters:
FIFO_W, 32, FIFO word width; fixed at 32, 4 bytes per word
TIMEOUT_CYCLES, 1024, max sd_clock cycles from end bit to CRC-status start bit
BUSY_TIMEOUT, 65535, max cycles DAT0 may stay low (busy) after the token

Ports:
sd_clock  in  1  SD-domain clock, also the FIFO read clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begin transfer; accepted only in IDLE
block_size  in  12  bytes per block; must be a multiple of 4, 4..2048
block_count  in  16  number of blocks
fifo_data  in  32  FIFO Data_out
fifo_empty  in  1  FIFO Empty_out
fifo_rd_en  out  1  FIFO enable_read; one-cycle pulse per word
dat_out  out  1  DAT0 drive value
dat_oe  out  1  DAT0 output enable
dat_in  in  1  DAT0 sampled value
busy  out  1  high from accepted start until return to IDLE
transfer_complete  out  1  one-cycle pulse after the last block's busy releases
blocks_done  out  16  blocks fully acknowledged; cleared on start
crc_status_err  out  1  sticky until next start; token other than 010
timeout_err  out  1  sticky; token or busy timeout
underrun_err  out  1  sticky; FIFO empty when a mid-block word is needed

Behaviour:
- Decided: one clock, sd_clock; reset synchronous, active-high, port name reset.
- Reset values: dat_out=1, dat_oe=0, fifo_rd_en=0, busy=0, transfer_complete=0, blocks_done=0, all error flags 0, state IDLE.
- Reset asserted mid-transfer: the line is released at the next edge and no pulse is produced.
- Illegal parameters: block_size=0, block_count=0 or block_size[1:0]!=0 at start. No line activity; transfer_complete pulses the cycle after start and blocks_done stays 0.
- FIFO read latency: fifo_data is valid in the cycle after the fifo_rd_en pulse. fifo_rd_en is never asserted while fifo_empty=1.
- States: IDLE -> FETCH -> LOAD -> START_BIT -> DATA -> CRC -> END_BIT -> NWR -> STAT_WAIT -> STAT -> BUSY_WAIT -> (FETCH | DONE). ERROR is reached from DATA, STAT_WAIT and BUSY_WAIT.
- FETCH: waits indefinitely while fifo_empty (line released, no error). Otherwise pulses fifo_rd_en.
- LOAD: latches the word. With a non-empty FIFO, the start bit (dat_out=0, dat_oe=1) is on the line 3 cycles after start is sampled.
- DATA: block_size*8 cycles.
  - Byte order is little-endian: byte0=[7:0] first, then [15:8], [23:16], [31:24].
  - Within each byte, MSB first.
- Prefetch: when words remain in the block, fifo_rd_en pulses in the cycle carrying bit 30 of the current word, so the next word is latched for seamless continuation.
- Underrun: if fifo_empty in that prefetch cycle, underrun_err is set and the FSM goes to ERROR.
- CRC: 16 cycles, MSB first.
  - CRC16-CCITT, x^16+x^12+x^5+1, init 0.
  - Computed over data bits only; cleared at each start bit.
- END_BIT: 1 cycle, dat_out=1.
- NWR: 2 cycles with dat_oe=0.
- STAT_WAIT: waits for dat_in=0. Timeout is counted from END_BIT; exceeding TIMEOUT_CYCLES sets timeout_err.
- STAT: samples 3 status bits plus the end bit.
  - Status 010 means accepted.
  - Any other status sets crc_status_err and goes to ERROR.
  - The end-bit value is ignored.
- BUSY_WAIT: continues while dat_in=0; BUSY_TIMEOUT sets timeout_err.
  - On release, blocks_done is incremented.
  - If blocks_done equals block_count: DONE, transfer_complete pulse, then IDLE.
  - Otherwise: FETCH for the next block.
- ERROR: dat_oe=0, busy drops, no transfer_complete; next state IDLE. Error flags clear only on the next accepted start.
- start outside IDLE is ignored.
- Counters:
  - Bit counter is 14-bit, sized for 2048*8.
  - Timeout counter is 16-bit and saturating.

Decomposition:
- Package sd_dat_pkg holds:
  - state enum
  - CRC16 polynomial 16'h1021
  - token constants: 3'b010 accepted, 3'b101 CRC error, 3'b110 write error
  - BYTES_PER_WORD
- Sub-module sd_crc16: serial CRC with inputs clear, enable and bit, and a 16-bit output. It will be reused by the receive path.

Test Plan:
- Reset and idle: after reset, observe 10 idle cycles -> dat_oe=0, dat_out=1, fifo_rd_en=0, busy=0, all flags 0.
- Single block of 0xFF:
  - Stimulus: block_size=512, block_count=1, FIFO holding 128 words of 0xFFFFFFFF; card returns token 0,010,1, then holds DAT0 low for 10 cycles.
  - Response: start bit at cycle 3, then 4096 ones, CRC 0x7FA1, end bit; blocks_done=1; one transfer_complete pulse.
- Byte order: block_size=4, word 0x04030201 -> data bits 00000001 00000010 00000011 00000100; the CRC matches the reference model.
- CRC-status rejection: block_count=2, token 101 on block 1 -> crc_status_err=1, no second start bit, blocks_done=0, no transfer_complete.
- Underrun: block_size=8 with only one word ever written -> underrun_err set at data bit 30, dat_oe=0 from the next cycle, busy=0.
- Timeouts:
  - dat_in held at 1 after the end bit -> timeout_err after TIMEOUT_CYCLES.
  - Separate run: dat_in held at 0 after a 010 token -> timeout_err after BUSY_TIMEOUT.
  - Also assert reset mid-DATA -> dat_oe=0 on the next edge.

Source files
------------

// File: rtl/sd_dat_pkg.sv
// rtl/sd_dat_pkg.sv - shared types and constants for the SD DAT0 data path
package sd_dat_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START_BIT,
        S_DATA,
        S_CRC,
        S_END_BIT,
        S_NWR,
        S_STAT_WAIT,
        S_STAT,
        S_BUSY_WAIT,
        S_DONE,
        S_ERROR
    } dat_tx_state_e;

    // CRC16-CCITT, x^16 + x^12 + x^5 + 1
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // CRC-status tokens returned by the card after each block
    localparam logic [2:0] TOKEN_ACCEPTED  = 3'b010;
    localparam logic [2:0] TOKEN_CRC_ERR   = 3'b101;
    localparam logic [2:0] TOKEN_WRITE_ERR = 3'b110;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - bit-serial CRC16-CCITT shared by the DAT transmit and receive paths
module sd_crc16
    import sd_dat_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = crc[15] ^ bit_in;

    // Shift one data bit per enabled cycle; clear wins so each block starts from zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_dat_tx.sv
// rtl/sd_dat_tx.sv - SD host DAT0 write-path transmitter fed from the ADMA data FIFO
module sd_dat_tx
    import sd_dat_pkg::*;
#(
    parameter int FIFO_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BUSY_TIMEOUT   = 65535
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              start,
    input  logic [11:0]       block_size,
    input  logic [15:0]       block_count,
    input  logic [FIFO_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              dat_out,
    output logic              dat_oe,
    input  logic              dat_in,
    output logic              busy,
    output logic              transfer_complete,
    output logic [15:0]       blocks_done,
    output logic              crc_status_err,
    output logic              timeout_err,
    output logic              underrun_err
);

    localparam logic [15:0] STAT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] BUSY_LIMIT = 16'(BUSY_TIMEOUT);

    dat_tx_state_e state_q, state_d;

    logic [FIFO_W-1:0] word_q;
    logic [13:0]       bit_cnt_q;
    logic [15:0]       tmo_cnt_q;
    logic [2:0]        tok_q;
    logic [11:0]       size_q;
    logic [15:0]       count_q;

    logic [13:0] last_bit;
    logic [4:0]  bit_in_word;
    logic        data_bit;
    logic        params_ok;
    logic        more_words;
    logic        prefetch_slot;
    logic [15:0] crc;
    logic        set_underrun;
    logic        set_timeout;
    logic        set_crc_err;
    logic        block_ack;

    assign params_ok   = (block_size != 12'd0) && (block_count != 16'd0) && (block_size[1:0] == 2'b00);
    assign last_bit    = 14'({size_q, 3'b000} - 15'd1);
    assign bit_in_word = bit_cnt_q[4:0];
    // Little-endian bytes, MSB first inside each byte
    assign data_bit    = word_q[{bit_in_word[4:3], ~bit_in_word[2:0]}];
    // Bit 30 of a word: the last word of the block ends at bit_cnt + 1 == last_bit
    assign more_words    = (bit_cnt_q + 14'd1) != last_bit;
    assign prefetch_slot = (bit_in_word == 5'd30) && more_words;

    sd_crc16 u_crc16 (
        .clk    (sd_clock),
        .reset  (reset),
        .clear  (state_q == S_START_BIT),
        .enable (state_q == S_DATA),
        .bit_in (data_bit),
        .crc    (crc)
    );

    // State register
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and line/FIFO/handshake outputs
    always_comb begin
        state_d           = state_q;
        fifo_rd_en        = 1'b0;
        dat_out           = 1'b1;
        dat_oe            = 1'b0;
        busy              = 1'b1;
        transfer_complete = 1'b0;
        set_underrun      = 1'b0;
        set_timeout       = 1'b0;
        set_crc_err       = 1'b0;
        block_ack         = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = params_ok ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_START_BIT;
            end
            S_START_BIT: begin
                dat_oe  = 1'b1;
                dat_out = 1'b0;
                state_d = S_DATA;
            end
            S_DATA: begin
                dat_oe  = 1'b1;
                dat_out = data_bit;
                if (prefetch_slot) begin
                    if (fifo_empty) begin
                        set_underrun = 1'b1;
                        state_d      = S_ERROR;
                    end else begin
                        fifo_rd_en = 1'b1;
                    end
                end else if (bit_cnt_q == last_bit) begin
                    state_d = S_CRC;
                end
            end
            S_CRC: begin
                dat_oe  = 1'b1;
                dat_out = crc[~bit_cnt_q[3:0]];
                if (bit_cnt_q[3:0] == 4'd15) begin
                    state_d = S_END_BIT;
                end
            end
            S_END_BIT: begin
                dat_oe  = 1'b1;
                dat_out = 1'b1;
                state_d = S_NWR;
            end
            S_NWR: begin
                if (bit_cnt_q[0]) begin
                    state_d = S_STAT_WAIT;
                end
            end
            S_STAT_WAIT: begin
                if (!dat_in) begin
                    state_d = S_STAT;
                end else if (tmo_cnt_q >= STAT_LIMIT) begin
                    set_timeout = 1'b1;
                    state_d     = S_ERROR;
                end
            end
            S_STAT: begin
                // Three status bits, then the end bit whose value is not checked
                if (bit_cnt_q[1:0] == 2'd3) begin
                    if (tok_q == TOKEN_ACCEPTED) begin
                        state_d = S_BUSY_WAIT;
                    end else begin
                        set_crc_err = 1'b1;
                        state_d     = S_ERROR;
                    end
                end
            end
            S_BUSY_WAIT: begin
                if (dat_in) begin
                    block_ack = 1'b1;
                    state_d   = ((blocks_done + 16'd1) == count_q) ? S_DONE : S_FETCH;
                end else if (tmo_cnt_q >= BUSY_LIMIT) begin
                    set_timeout = 1'b1;
                    state_d     = S_ERROR;
                end
            end
            S_DONE: begin
                transfer_complete = 1'b1;
                state_d           = S_IDLE;
            end
            S_ERROR: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: word buffer, per-state counters, token shifter, status and progress
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            word_q         <= '0;
            bit_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            tok_q          <= '0;
            size_q         <= '0;
            count_q        <= '0;
            blocks_done    <= '0;
            crc_status_err <= 1'b0;
            timeout_err    <= 1'b0;
            underrun_err   <= 1'b0;
        end else begin
            // The bit counter restarts on every state change and times each phase
            bit_cnt_q <= (state_d != state_q) ? 14'd0 : bit_cnt_q + 14'd1;

            // Response timeout runs from the end bit and saturates
            if (state_q == S_NWR || state_q == S_STAT_WAIT || state_q == S_BUSY_WAIT) begin
                if (tmo_cnt_q != 16'hFFFF) begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                end
            end else begin
                tmo_cnt_q <= '0;
            end

            if (state_q == S_LOAD) begin
                word_q <= fifo_data;
            end else if (state_q == S_DATA && bit_in_word == 5'd31 && bit_cnt_q != last_bit) begin
                word_q <= fifo_data;
            end

            if (state_q == S_STAT && bit_cnt_q[1:0] != 2'd3) begin
                tok_q <= {tok_q[1:0], dat_in};
            end

            if (state_q == S_IDLE && start) begin
                size_q         <= block_size;
                count_q        <= block_count;
                blocks_done    <= '0;
                crc_status_err <= 1'b0;
                timeout_err    <= 1'b0;
                underrun_err   <= 1'b0;
            end else begin
                if (block_ack)    blocks_done    <= blocks_done + 16'd1;
                if (set_crc_err)  crc_status_err <= 1'b1;
                if (set_timeout)  timeout_err    <= 1'b1;
                if (set_underrun) underrun_err   <= 1'b1;
            end
        end
    end

endmodule
